// File: rtl/alu_tx_packer.sv
// alu_tx_packer: merges the echo byte stream and serialized 32-bit ALU results
// into one AXI-stream byte channel toward uart_tx, through a FWFT byte FIFO.
module alu_tx_packer #(
  parameter int unsigned DepthLog2 = 4,
  parameter int unsigned WordBytes = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [7:0]               byte_data_i,
  input  logic                     byte_valid_i,
  output logic                     byte_ready_o,
  input  logic [8*WordBytes-1:0]   word_data_i,
  input  logic                     word_valid_i,
  output logic                     word_ready_o,
  output logic [7:0]               m_axis_tdata_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic [DepthLog2:0]       count_o,
  output logic                     busy_o
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam int unsigned CntW  = DepthLog2 + 1;
  localparam int unsigned WordW = 8 * WordBytes;
  localparam int unsigned IdxW  = (WordBytes > 1) ? $clog2(WordBytes) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [CntW-1:0]      free_c;
  logic [WordW-1:0]     word_q;
  logic [IdxW-1:0]      idx_q;
  logic                 active_q;

  logic                 push_c;
  logic                 pop_c;
  logic [7:0]           push_data_c;
  logic                 load_word_c;
  logic                 word_ready_c;
  logic                 byte_ready_c;
  logic                 full_c;
  logic                 empty_c;

  assign full_c  = (count_q == CntW'(Depth));
  assign empty_c = (count_q == CntW'(0));
  assign free_c  = CntW'(Depth) - count_q;
  assign pop_c   = !empty_c && m_axis_tready_i;

  // Holds both ready outputs low during reset and for the first cycle after release
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  // Write FSM state register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write FSM next state, source arbitration (word wins) and FIFO push control
  always_comb begin
    state_d      = state_q;
    push_c       = 1'b0;
    push_data_c  = byte_data_i;
    load_word_c  = 1'b0;
    word_ready_c = 1'b0;
    byte_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        word_ready_c = active_q && (free_c >= CntW'(WordBytes));
        byte_ready_c = active_q && !full_c && !(word_valid_i && word_ready_c);
        if (word_valid_i && word_ready_c) begin
          load_word_c = 1'b1;
          state_d     = SER;
        end else if (byte_valid_i && byte_ready_c) begin
          push_c = 1'b1;
        end
      end
      SER: begin
        push_c      = 1'b1;
        push_data_c = word_q[7:0];
        if (idx_q == IdxW'(WordBytes - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result shift register: low byte is always the next one to push
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load_word_c) begin
      word_q <= word_data_i;
      idx_q  <= '0;
    end else if (state_q == SER) begin
      word_q <= word_q >> 8;
      idx_q  <= idx_q + IdxW'(1);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + DepthLog2'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + DepthLog2'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= push_data_c;
    end
  end

  assign m_axis_tdata_o  = empty_c ? 8'h00 : mem_q[rd_ptr_q];
  assign m_axis_tvalid_o = !empty_c;
  assign count_o         = count_q;
  assign busy_o          = (state_q == SER) || !empty_c;
  assign byte_ready_o    = byte_ready_c;
  assign word_ready_o    = word_ready_c;

  // Overflow and underflow are excluded by the acceptance checks
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!reset_ni)
    !(push_c && full_c));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!reset_ni)
    !(pop_c && empty_c));

endmodule

// File: tb/tb_alu_tx_packer.sv
// tb_alu_tx_packer: scoreboard bench for alu_tx_packer.
module tb_alu_tx_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic [4:0]  count;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;
  int n_pops = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  alu_tx_packer #(.DepthLog2(4), .WordBytes(4)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .byte_data_i    (byte_data),
    .byte_valid_i   (byte_valid),
    .byte_ready_o   (byte_ready),
    .word_data_i    (word_data),
    .word_valid_i   (word_valid),
    .word_ready_o   (word_ready),
    .m_axis_tdata_o (tdata),
    .m_axis_tvalid_o(tvalid),
    .m_axis_tready_i(tready),
    .count_o        (count),
    .busy_o         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: handshakes seen at the falling edge take effect on the next rising edge
  always @(negedge clk) begin
    logic [31:0] want;
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (byte_valid && byte_ready) exp_q.push_back(byte_data);
      if (word_valid && word_ready) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(word_data[8*i +: 8]);
      end
      if (tvalid && tready) begin
        n_pops++;
        if (exp_q.size() != 0) want = 32'(exp_q.pop_front());
        else want = 32'hDEAD_BEEF;
        check("tdata", 32'(tdata), want);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_byte_ready();
    for (int i = 0; i < 64 && !byte_ready; i++) tick();
    check("byte_ready_wait", 32'(byte_ready), 32'd1);
  endtask

  task automatic wait_word_ready();
    for (int i = 0; i < 64 && !word_ready; i++) tick();
    check("word_ready_wait", 32'(word_ready), 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    #1;
    wait_byte_ready();
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && busy; i++) tick();
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  logic [7:0] t1_bytes [6] = '{8'hec, 8'h00, 8'h06, 8'h00, 8'h48, 8'h69};
  logic       t5_seq   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int         pops0;
    logic [7:0] prev;

    reset_n    = 1'b0;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    word_data  = 32'h0;
    word_valid = 1'b0;
    tready     = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_word_ready", 32'(word_ready), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();
    check("idle_byte_ready", 32'(byte_ready), 32'd1);
    check("idle_word_ready", 32'(word_ready), 32'd1);

    // 1: echo bytes back-to-back, one-cycle latency
    tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_byte(t1_bytes[i]);
      check("t1_tvalid", 32'(tvalid), 32'd1);
      check("t1_head", 32'(tdata), 32'(t1_bytes[i]));
      check("t1_count", 32'(count), 32'd1);
    end
    tick();
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: word serialization, little-endian
    word_data  = 32'h94B0_4620;
    word_valid = 1'b1;
    #1;
    wait_word_ready();
    tick();
    word_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t2_word_ready_ser", 32'(word_ready), 32'd0);
      check("t2_busy_ser", 32'(busy), 32'd1);
      tick();
    end
    check("t2_word_ready_back", 32'(word_ready), 32'd1);
    drain();

    // 3: fill the FIFO with the sink stalled
    tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("t3_count", 32'(count), 32'(i));
      if (i == 12) check("t3_word_ready_at12", 32'(word_ready), 32'd1);
      if (i == 13) begin
        word_data  = 32'hCAFE_F00D;
        word_valid = 1'b1;
        #1;
        check("t3_word_ready_at13", 32'(word_ready), 32'd0);
      end
      push_byte(8'(i));
    end
    #1;
    check("t3_count_full", 32'(count), 32'd16);
    check("t3_byte_ready_full", 32'(byte_ready), 32'd0);
    check("t3_word_ready_full", 32'(word_ready), 32'd0);
    word_valid = 1'b0;
    pops0  = n_pops;
    tready = 1'b1;
    drain();
    check("t3_pops", 32'(n_pops - pops0), 32'd16);

    // 4: simultaneous word and byte, word wins
    word_data  = 32'h1122_3344;
    word_valid = 1'b1;
    byte_data  = 8'hAA;
    byte_valid = 1'b1;
    #1;
    check("t4_word_ready", 32'(word_ready), 32'd1);
    check("t4_byte_ready", 32'(byte_ready), 32'd0);
    tick();
    word_valid = 1'b0;
    wait_byte_ready();
    tick();
    byte_valid = 1'b0;
    drain();

    // 5: output backpressure
    tready = 1'b0;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    tick();
    for (int k = 0; k < 6; k++) begin
      tready = t5_seq[k];
      prev   = tdata;
      tick();
      if (!t5_seq[k]) begin
        check("t5_hold_tdata", 32'(tdata), 32'(prev));
        check("t5_hold_tvalid", 32'(tvalid), 32'd1);
      end
    end
    check("t5_count_end", 32'(count), 32'd0);

    // 6: reset in the middle of serialization
    tready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'hB0 + 8'(i));
    word_data  = 32'h0102_0304;
    word_valid = 1'b1;
    #1;
    wait_word_ready();
    tick();
    word_valid = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(tvalid), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check("t6_post_tvalid", 32'(tvalid), 32'd0);
    check("t6_post_count", 32'(count), 32'd0);
    pops0  = n_pops;
    tready = 1'b1;
    push_byte(8'h5A);
    drain();
    repeat (3) tick();
    check("t6_pops", 32'(n_pops - pops0), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_tx_packer.md
Name: alu_tx_packer

Overview:
- Sits between the UART ALU packet handler and `uart_tx` on the transmit side of `alu_wrap`.
- Merges two response sources into one AXI-stream byte channel toward `uart_tx`:
  - the echo byte stream, forwarded byte by byte;
  - 32-bit ALU results (add, etc.), serialized into 4 bytes, little-endian.
- A byte FIFO absorbs UART backpressure, so the handler is never stalled mid-result.

Parameters:
- DepthLog2, 4, log2 of the byte FIFO depth (default depth 16); must be >= 2.
- WordBytes, 4, bytes per result word; word width = 8*WordBytes.

Ports:
- clk_i  input  1  system clock
- reset_ni  input  1  asynchronous, active-low reset
- byte_data_i  input  8  echo byte
- byte_valid_i  input  1  echo byte valid
- byte_ready_o  output  1  echo byte accepted when valid&&ready
- word_data_i  input  8*WordBytes  ALU result
- word_valid_i  input  1  result valid
- word_ready_o  output  1  result accepted when valid&&ready
- m_axis_tdata_o  output  8  byte to uart_tx
- m_axis_tvalid_o  output  1  output byte valid
- m_axis_tready_i  input  1  uart_tx ready
- count_o  output  DepthLog2+1  FIFO occupancy, 0..2**DepthLog2
- busy_o  output  1  high while the serializer is active or the FIFO is non-empty

Behaviour:
- Reset (async assert, sync release): FIFO pointers and count go to 0 and the write FSM goes to IDLE. Outputs: tvalid=0, tdata=0, count_o=0, busy_o=0, byte_ready_o=0, word_ready_o=0. Reset mid-serialization discards the partial word and all queued bytes.
- FIFO: first-word-fall-through, depth D=2**DepthLog2, pointers wrap modulo D.
  - The FIFO head drives m_axis_tdata_o.
  - m_axis_tvalid_o = (count != 0).
  - A pop occurs on tvalid && tready.
- Write FSM states:
  - IDLE: accept from one source per cycle.
    - word_ready_o = (free >= WordBytes), where free = D - count.
    - byte_ready_o = (count != D) && !(word_valid_i && word_ready_o). The word path has priority on a simultaneous request.
    - On a word handshake, latch the word into a shift register, set idx=0, go to SER.
    - On a byte handshake, push byte_data_i.
  - SER: push word byte idx (bits 8*idx+7:8*idx) each cycle, idx incrementing.
    - byte_ready_o = 0 and word_ready_o = 0 throughout.
    - After pushing byte WordBytes-1, return to IDLE. That cycle still has ready low; new acceptance starts the following cycle.
    - Space is guaranteed by the acceptance check, so SER never stalls and takes exactly WordBytes cycles.
- Simultaneous push and pop in the same cycle: count is unchanged and both operations take effect.
  - Full FIFO: byte_ready_o=0 even if a pop occurs that cycle (no same-cycle pass-through).
  - Empty FIFO: a pushed byte appears on m_axis at the next rising edge (1-cycle latency); it is not combinationally bypassed.
- AXI rule: while tvalid && !tready, tdata_o and tvalid_o hold stable.
- busy_o = (state==SER) || (count != 0).
- The block never reorders bytes: output order equals push order. Packet boundaries are upstream's responsibility.
- No overflow or underflow is possible by construction. An assertion flags push-when-full and pop-when-empty.

Test Plan:
1. Echo path:
   - Stimulus: tready=1; push 0xec,0x00,0x06,0x00,0x48,0x69 back-to-back.
   - Required: m_axis emits the same 6 bytes in order, each one cycle after its accept; count_o never exceeds 1; busy_o drops after the last pop.
2. Word path:
   - Stimulus: word_data_i=0x94B04620 (0x0d4b02ff+0x87654321), tready=1.
   - Required: output 0x20,0x46,0xB0,0x94; word_ready_o low for 4 cycles after accept.
3. Full FIFO:
   - Stimulus: tready=0; push 16 bytes 0x00..0x0F; assert word_valid_i with count_o=13.
   - Required: word_ready_o=0 once count_o>12; byte_ready_o=0 at count_o=16.
   - Then set tready=1: output 0x00..0x0F in order.
4. Priority:
   - Stimulus: empty FIFO, IDLE; in the same cycle word_valid_i (0x11223344) and byte_valid_i (0xAA).
   - Required: word accepted first; output 0x44,0x33,0x22,0x11,0xAA.
5. Backpressure:
   - Stimulus: queue 0x01,0x02,0x03; toggle tready 1,0,0,1,0,1.
   - Required: tdata holds stable while tready=0; output sequence exactly 0x01,0x02,0x03.
6. Reset mid-operation:
   - Stimulus: assert reset_ni=0 asynchronously during SER idx=2 with 5 bytes queued.
   - Required: tvalid=0 and count_o=0 immediately; after release, no stale bytes are emitted, and a new echo byte 0x5A is output alone.
